// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: the slot record, register
// constants and the saturating tnew decrement.
package fwd_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  // Slot tnew field is stored at this width; the TW parameter must not exceed it.
  localparam int TNEW_W = 8;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  function automatic logic [TNEW_W-1:0] tnew_sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// One decode read port: finds the youngest in-flight producer of rd_addr_i and
// decides between forwarding, falling back to the register file, or stalling.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int DW    = 32,
  parameter int TW    = 2
) (
  input  slot_t [DEPTH-1:0]    slots_i,
  input  logic  [REG_AW-1:0]   rd_addr_i,
  input  logic  [TW-1:0]       rd_tuse_i,
  input  logic  [DW-1:0]       rf_data_i,
  input  logic  [DEPTH*DW-1:0] stage_data_i,
  output logic  [DW-1:0]       fwd_data_o,
  output logic                 fwd_hit_o,
  output logic                 stall_o
);

  logic [DEPTH-1:0]  addr_eq;
  logic              match_found;
  logic [TNEW_W-1:0] match_tnew;
  logic [TNEW_W-1:0] tuse_ext;
  logic [DW-1:0]     match_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign addr_eq[gi] = slots_i[gi].valid && (slots_i[gi].addr == rd_addr_i);
    end
  endgenerate

  // Scan oldest to youngest so the lowest-index match overwrites; a pending
  // younger producer therefore hides any older completed one.
  always_comb begin
    match_found = 1'b0;
    match_tnew  = '0;
    match_data  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (addr_eq[i]) begin
        match_found = 1'b1;
        match_tnew  = slots_i[i].tnew;
        match_data  = stage_data_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    tuse_ext          = '0;
    tuse_ext[TW-1:0]  = rd_tuse_i;
  end

  always_comb begin
    fwd_data_o = rf_data_i;
    fwd_hit_o  = 1'b0;
    stall_o    = 1'b0;
    if ((rd_addr_i != ZERO_REG) && match_found) begin
      if (match_tnew == '0) begin
        fwd_data_o = match_data;
        fwd_hit_o  = 1'b1;
      end else if (match_tnew > tuse_ext) begin
        stall_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-side hazard/forwarding unit: a shift-register scoreboard of in-flight
// register writes, per-port forward resolution and the decode stall.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int DW    = 32,
  parameter int TW    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [REG_AW-1:0]       issue_addr,
  input  logic [TW-1:0]           issue_tnew,
  input  logic                    flush,
  input  logic [NREAD*REG_AW-1:0] rd_addr,
  input  logic [NREAD*TW-1:0]     rd_tuse,
  input  logic [NREAD*DW-1:0]     rf_data,
  input  logic [DEPTH*DW-1:0]     stage_data,
  output logic [NREAD*DW-1:0]     fwd_data,
  output logic [NREAD-1:0]        fwd_hit,
  output logic                    stall,
  output logic [31:0]             stall_cnt
);

  slot_t [DEPTH-1:0] slot_q;
  slot_t             slot0_d;
  logic [31:0]       stall_cnt_q;

  logic [DW-1:0] port_data  [NREAD];
  logic          port_hit   [NREAD];
  logic          port_stall [NREAD];

  // Stall and flush both collapse to one bubble entering E.
  always_comb begin
    slot0_d = '0;
    if (!stall && !flush) begin
      slot0_d.valid              = issue_valid && (issue_addr != ZERO_REG);
      slot0_d.addr               = issue_addr;
      slot0_d.tnew[TW-1:0]       = issue_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      slot_q[0] <= slot0_d;
      for (int i = 1; i < DEPTH; i++) begin
        slot_q[i].valid <= slot_q[i-1].valid;
        slot_q[i].addr  <= slot_q[i-1].addr;
        slot_q[i].tnew  <= tnew_sat_dec(slot_q[i-1].tnew);
      end
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
      fwd_port_match #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .TW    (TW)
      ) u_match (
        .slots_i      (slot_q),
        .rd_addr_i    (rd_addr[gi*REG_AW +: REG_AW]),
        .rd_tuse_i    (rd_tuse[gi*TW +: TW]),
        .rf_data_i    (rf_data[gi*DW +: DW]),
        .stage_data_i (stage_data),
        .fwd_data_o   (port_data[gi]),
        .fwd_hit_o    (port_hit[gi]),
        .stall_o      (port_stall[gi])
      );
    end
  endgenerate

  always_comb begin
    fwd_data = '0;
    fwd_hit  = '0;
    stall    = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      fwd_data[p*DW +: DW] = port_data[p];
      fwd_hit[p]           = port_hit[p];
      stall                = stall | port_stall[p];
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random
// traffic compared against an issue-history model of in-flight writes.
module tb_fwd_scoreboard;

  localparam int NREAD = 2;
  localparam int DEPTH = 3;
  localparam int DW    = 32;
  localparam int TW    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic [4:0]           issue_addr;
  logic [TW-1:0]        issue_tnew;
  logic                 flush;
  logic [NREAD*5-1:0]   rd_addr;
  logic [NREAD*TW-1:0]  rd_tuse;
  logic [NREAD*DW-1:0]  rf_data;
  logic [DEPTH*DW-1:0]  stage_data;
  logic [NREAD*DW-1:0]  fwd_data;
  logic [NREAD-1:0]     fwd_hit;
  logic                 stall;
  logic [31:0]          stall_cnt;

  int errors = 0;
  int checks = 0;

  fwd_scoreboard #(.NREAD(NREAD), .DEPTH(DEPTH), .DW(DW), .TW(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .issue_tnew (issue_tnew),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_tuse    (rd_tuse),
    .rf_data    (rf_data),
    .stage_data (stage_data),
    .fwd_data   (fwd_data),
    .fwd_hit    (fwd_hit),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: every accepted write with the cycle it was issued in. An entry
  // issued in cycle c sits in slot (now-c-1) and still needs tnew-slot cycles.
  typedef struct {
    int         cyc;
    logic [4:0] addr;
    int         tnew;
  } ent_t;

  ent_t        hist[$];
  int          now = 0;
  logic [31:0] exp_cnt = 0;

  task automatic model_eval(output logic [NREAD*DW-1:0] d, output logic [NREAD-1:0] h,
                            output logic s);
    d = rf_data;
    h = '0;
    s = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      logic [4:0] a;
      int tu;
      a  = rd_addr[p*5 +: 5];
      tu = int'(rd_tuse[p*TW +: TW]);
      if (a != 5'd0) begin
        for (int k = hist.size() - 1; k >= 0; k--) begin
          int slot;
          int rem;
          slot = now - hist[k].cyc - 1;
          if (slot < DEPTH && hist[k].addr == a) begin
            rem = hist[k].tnew - slot;
            if (rem < 0) rem = 0;
            if (rem == 0) begin
              d[p*DW +: DW] = stage_data[slot*DW +: DW];
              h[p] = 1'b1;
            end else if (rem > tu) begin
              s = 1'b1;
            end
            break;
          end
        end
      end
    end
  endtask

  // Checks the whole output set against the model, then clocks one cycle.
  task automatic run_cycle(input string tag);
    logic [NREAD*DW-1:0] ed;
    logic [NREAD-1:0]    eh;
    logic                es;
    #2;
    model_eval(ed, eh, es);
    checks++;
    if (stall !== es) begin
      errors++;
      $display("FAIL %s stall: got %0b expected %0b", tag, stall, es);
    end
    checks++;
    if (fwd_hit !== eh) begin
      errors++;
      $display("FAIL %s fwd_hit: got %b expected %b", tag, fwd_hit, eh);
    end
    checks++;
    if (fwd_data !== ed) begin
      errors++;
      $display("FAIL %s fwd_data: got %h expected %h", tag, fwd_data, ed);
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, exp_cnt);
    end
    $display("cyc=%0d %s iss=%0b/%0d/%0d fl=%0b rd=%h stall=%0b hit=%b data=%h cnt=%0d",
             now, tag, issue_valid, issue_addr, issue_tnew, flush, rd_addr, stall,
             fwd_hit, fwd_data, stall_cnt);
    if (reset) begin
      hist.delete();
      exp_cnt = 0;
    end else begin
      if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      if (issue_valid && issue_addr != 5'd0 && !es && !flush)
        hist.push_back('{now, issue_addr, int'(issue_tnew)});
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic set_port(input int p, input logic [4:0] a, input logic [TW-1:0] tu,
                          input logic [DW-1:0] rf);
    rd_addr[p*5 +: 5]   = a;
    rd_tuse[p*TW +: TW] = tu;
    rf_data[p*DW +: DW] = rf;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    flush       = 1'b0;
    set_port(0, 5'd0, 2'd0, 32'h1111_0000);
    set_port(1, 5'd0, 2'd0, 32'h2222_0000);
    for (int i = 0; i < n; i++) run_cycle("idle");
  endtask

  task automatic test_reset;
    set_port(0, 5'd8, 2'd0, 32'hAAAA_0008);
    set_port(1, 5'd9, 2'd0, 32'hBBBB_0009);
    #2;
    checks++;
    if (stall !== 1'b0 || fwd_hit !== 2'b00 || fwd_data !== rf_data || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got stall=%0b hit=%b data=%h cnt=%0d required 0/00/%h/0",
               stall, fwd_hit, fwd_data, stall_cnt, rf_data);
    end
    run_cycle("reset");
  endtask

  task automatic test_forward;
    issue_valid = 1'b1; issue_addr = 5'd8; issue_tnew = 2'd0;
    run_cycle("fwd_issue");
    issue_valid = 1'b0;
    set_port(0, 5'd8, 2'd0, 32'hDEAD_0008);
    stage_data[0 +: DW] = 32'h0000_1234;
    #2;
    checks++;
    if (fwd_data[0 +: DW] !== 32'h0000_1234 || fwd_hit[0] !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL fwd_e: got data=%h hit=%0b stall=%0b required 00001234/1/0",
               fwd_data[0 +: DW], fwd_hit[0], stall);
    end
    run_cycle("fwd_use");
    idle(DEPTH);
  endtask

  task automatic test_load_stall;
    logic [31:0] cnt0;
    issue_valid = 1'b1; issue_addr = 5'd9; issue_tnew = 2'd2;
    run_cycle("load_issue");
    stage_data = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    set_port(0, 5'd9, 2'd0, 32'hDEAD_0009);
    set_port(1, 5'd10, 2'd3, 32'hDEAD_000A);
    issue_addr = 5'd10; issue_tnew = 2'd0;
    cnt0 = stall_cnt;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (stall !== (c < 2)) begin
        errors++;
        $display("FAIL load_stall_c%0d: got stall=%0b required %0b", c, stall, (c < 2));
      end
      if (c == 2) begin
        checks++;
        if (fwd_data[0 +: DW] !== 32'hC2C2_0002 || fwd_hit !== 2'b01 ||
            stall_cnt - cnt0 !== 32'd2) begin
          errors++;
          $display("FAIL load_resolve: got data=%h hit=%b dcnt=%0d required c2c20002/01/2",
                   fwd_data[0 +: DW], fwd_hit, stall_cnt - cnt0);
        end
      end
      run_cycle("load_read");
    end
    idle(DEPTH);
  endtask

  task automatic test_load_tuse1;
    issue_valid = 1'b1; issue_addr = 5'd9; issue_tnew = 2'd2;
    run_cycle("tuse1_issue");
    issue_valid = 1'b0;
    set_port(0, 5'd9, 2'd1, 32'h5555_0009);
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (stall !== (c == 0) || fwd_hit[0] !== 1'b0 || fwd_data[0 +: DW] !== 32'h5555_0009) begin
        errors++;
        $display("FAIL tuse1_c%0d: got stall=%0b hit=%0b data=%h required %0b/0/55550009",
                 c, stall, fwd_hit[0], fwd_data[0 +: DW], (c == 0));
      end
      run_cycle("tuse1_read");
    end
    idle(DEPTH);
  endtask

  task automatic test_youngest_and_zero;
    issue_valid = 1'b1; issue_addr = 5'd5; issue_tnew = 2'd0;
    run_cycle("y_issue_old");
    run_cycle("y_issue_new");
    issue_valid = 1'b0;
    stage_data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    set_port(0, 5'd5, 2'd0, 32'h0000_0FFF);
    #2;
    checks++;
    if (fwd_data[0 +: DW] !== 32'h0000_000A || fwd_hit[0] !== 1'b1) begin
      errors++;
      $display("FAIL youngest: got data=%h hit=%0b required 0000000a/1",
               fwd_data[0 +: DW], fwd_hit[0]);
    end
    run_cycle("y_read");
    idle(DEPTH);
    issue_valid = 1'b1; issue_addr = 5'd0; issue_tnew = 2'd0;
    run_cycle("zero_issue");
    issue_valid = 1'b0;
    set_port(0, 5'd0, 2'd0, 32'h1357_9BDF);
    stage_data[0 +: DW] = 32'h2468_ACE0;
    #2;
    checks++;
    if (fwd_hit[0] !== 1'b0 || fwd_data[0 +: DW] !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL zero_reg: got hit=%0b data=%h required 0/13579bdf",
               fwd_hit[0], fwd_data[0 +: DW]);
    end
    run_cycle("zero_read");
    idle(DEPTH);
  endtask

  task automatic test_flush;
    issue_valid = 1'b1; issue_addr = 5'd7; issue_tnew = 2'd0; flush = 1'b1;
    run_cycle("flush_issue");
    issue_valid = 1'b0; flush = 1'b0;
    set_port(0, 5'd7, 2'd0, 32'h7777_0007);
    #2;
    checks++;
    if (fwd_hit[0] !== 1'b0 || fwd_data[0 +: DW] !== 32'h7777_0007) begin
      errors++;
      $display("FAIL flush: got hit=%0b data=%h required 0/77770007", fwd_hit[0], fwd_data[0 +: DW]);
    end
    run_cycle("flush_read");
    idle(DEPTH);
  endtask

  task automatic test_reset_mid;
    issue_valid = 1'b1; issue_addr = 5'd9; issue_tnew = 2'd2;
    run_cycle("rmid_issue");
    issue_valid = 1'b0;
    set_port(0, 5'd9, 2'd0, 32'h9999_0009);
    reset = 1'b1;
    #2;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pending: got stall=%0b required 1", stall);
    end
    run_cycle("rmid_reset");
    reset = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rmid_after: got stall=%0b cnt=%0d required 0/0", stall, stall_cnt);
    end
    run_cycle("rmid_after");
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_addr  = 5'($urandom_range(0, 4));
      issue_tnew  = TW'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NREAD; p++)
        set_port(p, 5'($urandom_range(0, 4)), TW'($urandom_range(0, 3)), $urandom);
      for (int k = 0; k < DEPTH; k++) stage_data[k*DW +: DW] = $urandom;
      run_cycle("rand");
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_addr = '0; issue_tnew = '0; flush = 1'b0;
    rd_addr = '0; rd_tuse = '0; rf_data = '0; stage_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_forward;
    test_load_stall;
    test_load_tuse1;
    test_youngest_and_zero;
    test_flush;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
